regfile_scb: RTL and testbench

REGFILE_SCB -- requirements
Module: regfile_scb

---
 rtl/regfile_pkg.sv | 14 +
 rtl/reg_scoreboard.sv | 72 +++++++
 rtl/regfile_scb.sv | 78 +++++++
 tb/tb_regfile_scb.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with its issue scoreboard.
package regfile_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NREAD = 2;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    // Index of the hardwired zero register (XZR): always the last one.
    function automatic int xzr_idx(input int nregs);
        return nregs - 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, busy/stall for read ports,
// and a sticky error for writes that land on a register nobody reserved.
// Addresses at or above XZR (including out-of-range ones) never hold a
// pending bit and never report busy.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int NREAD  = DEF_NREAD,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we3,
    input  logic [AW-1:0]            wa3,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic [NREAD-1:0]         re,
    input  logic [NREAD-1:0][AW-1:0] ra,
    output logic [NREAD-1:0]         busy,
    output logic                     stall,
    output logic                     err
);

    localparam logic [AW-1:0] XZR = AW'(xzr_idx(NREGS));

    logic [NREGS-1:0] sb_q, sb_d;
    logic             err_q, err_d;
    logic             wr_ok, rsv_ok;

    assign wr_ok  = we3 && (wa3 < XZR);
    assign rsv_ok = rsv_en && (rsv_addr < XZR);

    // Next pending state: the write clears first, then a reserve sets, so a
    // same-register write+reserve leaves the bit set for the new producer.
    always_comb begin
        sb_d  = sb_q;
        err_d = err_q;
        if (wr_ok) begin
            if (!sb_q[wa3]) err_d = 1'b1;
            sb_d[wa3] = 1'b0;
        end
        if (rsv_ok) sb_d[rsv_addr] = 1'b1;
    end

    // Scoreboard and error registers; reset drops every outstanding reservation.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sb_q  <= sb_d;
            err_q <= err_d;
        end
    end

    // Per-port busy; a same-cycle forwarded write resolves the hazard.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (re[i] && (ra[i] < XZR) && sb_q[ra[i]]) begin
                busy[i] = 1'b1;
                if ((BYPASS != 0) && we3 && (wa3 == ra[i])) busy[i] = 1'b0;
            end
        end
    end

    assign stall = |busy;
    assign err   = err_q;

endmodule

// File: rtl/regfile_scb.sv
// Multi-read, single-write register file with a zero register (XZR), optional
// write-to-read forwarding, and an attached pending-write scoreboard.
module regfile_scb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREGS  = DEF_NREGS,
    parameter int NREAD  = DEF_NREAD,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we3,
    input  logic [AW-1:0]               wa3,
    input  logic [WIDTH-1:0]            wd3,
    input  logic [NREAD-1:0]            re,
    input  logic [NREAD-1:0][AW-1:0]    ra,
    output logic [NREAD-1:0][WIDTH-1:0] rd,
    input  logic                        rsv_en,
    input  logic [AW-1:0]               rsv_addr,
    output logic [NREAD-1:0]            busy,
    output logic                        stall,
    output logic                        err
);

    localparam logic [AW-1:0] XZR = AW'(xzr_idx(NREGS));

    logic [WIDTH-1:0] regs_q [NREGS];
    logic             wr_ok;

    assign wr_ok = we3 && (wa3 < XZR);

    // Storage: reset seeds each register with its own index (XZR with 0).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= (k == NREGS - 1) ? '0 : WIDTH'(k);
            end
        end else if (wr_ok) begin
            regs_q[wa3] <= wd3;
        end
    end

    // Combinational read ports with XZR forced to zero and optional forwarding.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (ra[i] >= XZR) begin
                rd[i] = '0;
            end else if ((BYPASS != 0) && we3 && (wa3 == ra[i])) begin
                rd[i] = wd3;
            end else begin
                rd[i] = regs_q[ra[i]];
            end
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .we3      (we3),
        .wa3      (wa3),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .re       (re),
        .ra       (ra),
        .busy     (busy),
        .stall    (stall),
        .err      (err)
    );

endmodule

// File: tb/tb_regfile_scb.sv
// Bench for regfile_scb: directed scenarios plus a random reserve/write/read
// phase. Expected read data is queued when stimulus is driven and popped when
// the outputs are sampled.
// Inputs change 1ns after a rising edge; outputs are sampled 3ns later.
module tb_regfile_scb;

    logic            clk;
    logic            reset;
    logic            we3;
    logic [4:0]      wa3;
    logic [63:0]     wd3;
    logic [1:0]      re;
    logic [1:0][4:0] ra;
    logic [1:0][63:0] rd;
    logic            rsv_en;
    logic [4:0]      rsv_addr;
    logic [1:0]      busy;
    logic            stall;
    logic            err;

    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [63:0] model [32];
    int          n_vec;
    int          n_bad;

    regfile_scb dut (
        .clk      (clk),
        .reset    (reset),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .re       (re),
        .ra       (ra),
        .rd       (rd),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (busy),
        .stall    (stall),
        .err      (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        we3 = 1'b0; wa3 = '0; wd3 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        re = '0; ra = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 31; k++) model[k] = 64'(k);
        model[31] = '0;
    endtask

    task automatic reserve(input logic [4:0] a);
        rsv_en = 1'b1; rsv_addr = a;
        tick();
        rsv_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        ra[0] = 5'd0; ra[1] = 5'd1; re = 2'b11;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        settle();
        n_vec++;
        if (busy !== 2'b00 || stall !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got busy=%b stall=%b err=%b, required 00 0 0", busy, stall, err);
        end
        for (int p = 0; p < 2; p++) begin
            exp_v = exp_q.pop_front();
            n_vec++;
            if (rd[p] !== exp_v) begin
                n_bad++;
                $display("FAIL reset_rd%0d: got %h, required %h", p, rd[p], exp_v);
            end
        end
    endtask

    task automatic test_read_pairs();
        do_reset();
        for (int k = 0; k < 31; k++) begin
            ra[0] = 5'(k); ra[1] = 5'(k + 1);
            exp_q.push_back(64'(k));
            exp_q.push_back((k + 1 == 31) ? 64'd0 : 64'(k + 1));
            settle();
            for (int p = 0; p < 2; p++) begin
                exp_v = exp_q.pop_front();
                n_vec++;
                if (rd[p] !== exp_v) begin
                    n_bad++;
                    $display("FAIL pair_%0d_rd%0d: got %h, required %h", k, p, rd[p], exp_v);
                end
            end
            #1;
        end
    endtask

    task automatic test_bypass();
        do_reset();
        we3 = 1'b1; wa3 = 5'd1; wd3 = 64'hC0CAC01A;
        ra[0] = 5'd1; ra[1] = 5'd1;
        exp_q.push_back(64'hC0CAC01A);
        exp_q.push_back(64'hC0CAC01A);
        settle();
        for (int p = 0; p < 2; p++) begin
            exp_v = exp_q.pop_front();
            n_vec++;
            if (rd[p] !== exp_v) begin
                n_bad++;
                $display("FAIL bypass_rd%0d: got %h, required %h", p, rd[p], exp_v);
            end
        end
        tick();
        we3 = 1'b0; wd3 = '0; wa3 = 5'd0;
        exp_q.push_back(64'hC0CAC01A);
        exp_q.push_back(64'hC0CAC01A);
        settle();
        for (int p = 0; p < 2; p++) begin
            exp_v = exp_q.pop_front();
            n_vec++;
            if (rd[p] !== exp_v) begin
                n_bad++;
                $display("FAIL persist_rd%0d: got %h, required %h", p, rd[p], exp_v);
            end
        end
    endtask

    task automatic test_no_write_xzr();
        do_reset();
        we3 = 1'b0; wa3 = 5'd12; wd3 = 64'hAAAAAAAA; ra[0] = 5'd12;
        tick();
        exp_q.push_back(64'd12);
        settle();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (rd[0] !== exp_v) begin
            n_bad++;
            $display("FAIL we3_low_rd: got %h, required %h", rd[0], exp_v);
        end
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hDEADBEEF; ra[0] = 5'd31; ra[1] = 5'd31;
        exp_q.push_back(64'd0);
        settle();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (rd[0] !== exp_v) begin
            n_bad++;
            $display("FAIL xzr_same_cycle_rd: got %h, required %h", rd[0], exp_v);
        end
        tick();
        we3 = 1'b0;
        exp_q.push_back(64'd0);
        settle();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (rd[1] !== exp_v || err !== 1'b0) begin
            n_bad++;
            $display("FAIL xzr_after: got rd=%h err=%b, required rd=%h err=0", rd[1], err, exp_v);
        end
    endtask

    task automatic test_reserve_busy();
        do_reset();
        reserve(5'd5);
        re = 2'b01; ra[0] = 5'd5; ra[1] = 5'd5;
        settle();
        n_vec++;
        if (busy !== 2'b01 || stall !== 1'b1) begin
            n_bad++;
            $display("FAIL rsv_busy: got busy=%b stall=%b, required 01 1", busy, stall);
        end
        we3 = 1'b1; wa3 = 5'd5; wd3 = 64'd7;
        exp_q.push_back(64'd7);
        settle();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (busy !== 2'b00 || stall !== 1'b0 || rd[0] !== exp_v) begin
            n_bad++;
            $display("FAIL rsv_write: got busy=%b stall=%b rd=%h, required 00 0 %h", busy, stall, rd[0], exp_v);
        end
        tick();
        we3 = 1'b0;
        exp_q.push_back(64'd7);
        settle();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (busy !== 2'b00 || err !== 1'b0 || rd[0] !== exp_v) begin
            n_bad++;
            $display("FAIL rsv_after: got busy=%b err=%b rd=%h, required 00 0 %h", busy, err, rd[0], exp_v);
        end
        // double reserve is not counted; one write clears it
        reserve(5'd6);
        reserve(5'd6);
        re = 2'b10; ra[1] = 5'd6;
        settle();
        n_vec++;
        if (busy !== 2'b10) begin
            n_bad++;
            $display("FAIL double_rsv_busy: got %b, required 10", busy);
        end
        we3 = 1'b1; wa3 = 5'd6; wd3 = 64'h66;
        tick();
        we3 = 1'b0;
        settle();
        n_vec++;
        if (busy !== 2'b00 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL double_rsv_clear: got busy=%b err=%b, required 00 0", busy, err);
        end
        // reserving XZR has no effect
        reserve(5'd31);
        re = 2'b11; ra[0] = 5'd31; ra[1] = 5'd31;
        settle();
        n_vec++;
        if (busy !== 2'b00) begin
            n_bad++;
            $display("FAIL xzr_rsv_busy: got %b, required 00", busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        reserve(5'd9);
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h99;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        we3 = 1'b0; rsv_en = 1'b0;
        re = 2'b01; ra[0] = 5'd9;
        settle();
        n_vec++;
        if (busy !== 2'b01 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rsv_same: got busy=%b err=%b, required 01 0", busy, err);
        end
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h33;
        tick();
        we3 = 1'b0;
        settle();
        n_vec++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got %b, required 1", err);
        end
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h9A;
        tick();
        we3 = 1'b0;
        tick();
        settle();
        n_vec++;
        if (err !== 1'b1 || busy !== 2'b00) begin
            n_bad++;
            $display("FAIL err_sticky: got err=%b busy=%b, required 1 00", err, busy);
        end
        do_reset();
        settle();
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_reset: got %b, required 0", err);
        end
    endtask

    task automatic test_reset_midseq();
        do_reset();
        we3 = 1'b1; wa3 = 5'd4; wd3 = 64'd99;
        tick();
        we3 = 1'b0;
        reserve(5'd4);
        re = 2'b01; ra[0] = 5'd4;
        exp_q.push_back(64'd99);
        settle();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (busy !== 2'b01 || rd[0] !== exp_v) begin
            n_bad++;
            $display("FAIL pre_reset: got busy=%b rd=%h, required 01 %h", busy, rd[0], exp_v);
        end
        reset = 1'b1;
        we3 = 1'b1; wa3 = 5'd4; wd3 = 64'd55; rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        we3 = 1'b0; rsv_en = 1'b0; reset = 1'b0;
        exp_q.push_back(64'd4);
        settle();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (busy !== 2'b00 || err !== 1'b0 || rd[0] !== exp_v) begin
            n_bad++;
            $display("FAIL post_reset: got busy=%b err=%b rd=%h, required 00 0 %h", busy, err, rd[0], exp_v);
        end
    endtask

    task automatic test_random();
        logic [4:0]  a;
        logic [63:0] d;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            a = 5'($urandom_range(0, 31));
            d = {$urandom, $urandom};
            reserve(a);
            we3 = 1'b1; wa3 = a; wd3 = d;
            if (a != 5'd31) model[a] = d;
            tick();
            we3 = 1'b0;
            ra[0] = a;
            ra[1] = 5'($urandom_range(0, 31));
            re = 2'b11;
            exp_q.push_back(model[ra[0]]);
            exp_q.push_back(model[ra[1]]);
            settle();
            for (int p = 0; p < 2; p++) begin
                exp_v = exp_q.pop_front();
                n_vec++;
                if (rd[p] !== exp_v) begin
                    n_bad++;
                    $display("FAIL rand_%0d_rd%0d: got %h, required %h", n, p, rd[p], exp_v);
                end
            end
            n_vec++;
            if (busy !== 2'b00 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_%0d_flags: got busy=%b err=%b, required 00 0", n, busy, err);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_read_pairs();
        test_bypass();
        test_no_write_xzr();
        test_reserve_busy();
        test_back_to_back();
        test_reset_midseq();
        test_random();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d leftover entries, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
